// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, requester enum, wait-counter width helper, all-ones byte enable.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_DM = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } requester_e;

    localparam int unsigned DEF_TIMEOUT = 15;
    localparam int unsigned DEF_DATA_W  = 32;

    // Counter width able to hold 0..timeout inclusive.
    function automatic int unsigned wait_w(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int unsigned WAIT_W = wait_w(DEF_TIMEOUT);

    localparam logic [DEF_DATA_W/8-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-cycle counter: clears to 0, counts while enabled, flags when LIMIT is reached.
// Latency: expired_o is registered-count based, valid the cycle the count equals LIMIT.
// Backpressure: none; the counter holds at LIMIT instead of wrapping.
// Ports: clk_i/rst_i (sync active-high), clr_i (force 0), en_i (count), expired_o (count == LIMIT).
module arb_wait_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned W     = WAIT_W,
    parameter int unsigned LIMIT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (DM), one access at a time.
// Latency: grant edge -> valid pulse 2 cycles minimum; a new grant may be issued in the valid cycle.
// Backpressure: requesters hold req until gnt; memory stalls via mem_ready_in, aborted after TIMEOUT.
// Ports: if_* fetch side, dm_* load/store side, mem_* memory macro side, err_out qualifies valid pulses,
//        busy_out = not IDLE. Optional macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive DM grants
//        with IF pending, the next contention goes to IF. Without it DM always wins contention.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned TIMEOUT      = 15,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                if_req_in,
    input  logic [ADDR_W-1:0]   if_addr_in,
    output logic                if_gnt_out,
    output logic [DATA_W-1:0]   if_rdata_out,
    output logic                if_valid_out,
    input  logic                dm_req_in,
    input  logic                dm_we_in,
    input  logic [ADDR_W-1:0]   dm_addr_in,
    input  logic [DATA_W-1:0]   dm_wdata_in,
    input  logic [DATA_W/8-1:0] dm_wr_mask_in,
    output logic                dm_gnt_out,
    output logic [DATA_W-1:0]   dm_rdata_out,
    output logic                dm_valid_out,
    output logic                err_out,
    output logic                mem_req_out,
    output logic                mem_we_out,
    output logic [ADDR_W-1:0]   mem_addr_out,
    output logic [DATA_W-1:0]   mem_wdata_out,
    output logic [DATA_W/8-1:0] mem_be_out,
    input  logic                mem_ready_in,
    input  logic [DATA_W-1:0]   mem_rdata_in,
    output logic                busy_out
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = wait_w(TIMEOUT);

    arb_state_e        state_q, state_d;
    requester_e        pick;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic              err_q, err_d;
    logic              starve_hit;
    logic              tmr_clr, tmr_en, tmr_expired;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;

    // IF wins contention only once DM has taken STARVE_LIMIT grants in a row over a waiting fetch.
    // The counter cannot overrun: at the limit a pending IF always wins, so DM grants stop counting.
    assign starve_hit = (starve_q >= STARVE_W'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (if_gnt_out) begin
            starve_d = '0;
        end else if (dm_gnt_out && if_req_in) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    // Grants are combinational in IDLE only; DM has priority (older instruction's memory op first).
    always_comb begin
        if_gnt_out = 1'b0;
        dm_gnt_out = 1'b0;
        pick       = REQ_DM;
        if (state_q == IDLE && !rst_in) begin
            if (dm_req_in && !(if_req_in && starve_hit)) begin
                dm_gnt_out = 1'b1;
                pick       = REQ_DM;
            end else if (if_req_in) begin
                if_gnt_out = 1'b1;
                pick       = REQ_IF;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        err_d       = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_clr = 1'b1;
                if (if_gnt_out || dm_gnt_out) begin
                    mem_req_d = 1'b1;
                    if (pick == REQ_DM) begin
                        state_d     = SERVE_DM;
                        mem_we_d    = dm_we_in;
                        mem_addr_d  = dm_addr_in;
                        mem_wdata_d = dm_wdata_in;
                        mem_be_d    = dm_we_in ? dm_wr_mask_in : '1;
                    end else begin
                        state_d     = SERVE_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_in;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                    end
                end
            end
            SERVE_IF, SERVE_DM: begin
                // Ready is checked before expiry so a completion in the final wait cycle still counts.
                if (mem_ready_in) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (state_q == SERVE_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata_in;
                    end else begin
                        dm_valid_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata_in;
                        end
                    end
                end else if (tmr_expired) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    err_d     = 1'b1;
                    if (state_q == SERVE_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = '0;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            err_q       <= err_d;
        end
    end

    // Wait count is 0 in the first SERVE cycle; abort happens in the cycle it equals TIMEOUT.
    arb_wait_timer #(
        .W     (CNT_W),
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    assign mem_req_out   = mem_req_q;
    assign mem_we_out    = mem_we_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_wdata_out = mem_wdata_q;
    assign mem_be_out    = mem_be_q;
    assign if_rdata_out  = if_rdata_q;
    assign dm_rdata_out  = dm_rdata_q;
    assign if_valid_out  = if_valid_q;
    assign dm_valid_out  = dm_valid_q;
    assign err_out       = err_q;
    assign busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for single-cycle behaviour plus hand sequences
// for timeout, ready-at-timeout, reset mid-access and the starvation pattern.
// Inputs change 1 time unit after posedge; outputs are sampled on the negedge.
module tb_mem_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_gnt_out;
    logic [31:0] if_rdata_out;
    logic        if_valid_out;
    logic        dm_req_in;
    logic        dm_we_in;
    logic [31:0] dm_addr_in;
    logic [31:0] dm_wdata_in;
    logic [3:0]  dm_wr_mask_in;
    logic        dm_gnt_out;
    logic [31:0] dm_rdata_out;
    logic        dm_valid_out;
    logic        err_out;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [3:0]  mem_be_out;
    logic        mem_ready_in;
    logic [31:0] mem_rdata_in;
    logic        busy_out;

    always #5 clk_in = ~clk_in;

    mem_port_arbiter dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .if_req_in     (if_req_in),
        .if_addr_in    (if_addr_in),
        .if_gnt_out    (if_gnt_out),
        .if_rdata_out  (if_rdata_out),
        .if_valid_out  (if_valid_out),
        .dm_req_in     (dm_req_in),
        .dm_we_in      (dm_we_in),
        .dm_addr_in    (dm_addr_in),
        .dm_wdata_in   (dm_wdata_in),
        .dm_wr_mask_in (dm_wr_mask_in),
        .dm_gnt_out    (dm_gnt_out),
        .dm_rdata_out  (dm_rdata_out),
        .dm_valid_out  (dm_valid_out),
        .err_out       (err_out),
        .mem_req_out   (mem_req_out),
        .mem_we_out    (mem_we_out),
        .mem_addr_out  (mem_addr_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_be_out    (mem_be_out),
        .mem_ready_in  (mem_ready_in),
        .mem_rdata_in  (mem_rdata_in),
        .busy_out      (busy_out)
    );

    typedef struct {
        string       name;
        logic        rst, ifr;
        logic [31:0] ia;
        logic        dmr, we;
        logic [31:0] da, wd;
        logic [3:0]  mk;
        logic        rdy;
        logic [31:0] rd;
        logic [7:0]  flags;   // {if_gnt, if_valid, dm_gnt, dm_valid, err, mem_req, mem_we, busy}
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwd, ird, drd;
    } vec_t;

    vec_t vecs[9];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    function automatic vec_t mkv(input string n,
                                 input logic [31:0] r, ifr, ia, dmr, we, da, wd, mk, rdy, rd,
                                 input logic [31:0] fl, ma, be, mwd, ird, drd);
        vec_t v;
        v.name = n;   v.rst = r[0];    v.ifr = ifr[0]; v.ia = ia;
        v.dmr = dmr[0]; v.we = we[0];  v.da = da;      v.wd = wd;
        v.mk = mk[3:0]; v.rdy = rdy[0]; v.rd = rd;
        v.flags = fl[7:0]; v.maddr = ma; v.be = be[3:0];
        v.mwd = mwd;  v.ird = ird;     v.drd = drd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return 32'({if_gnt_out, if_valid_out, dm_gnt_out, dm_valid_out,
                    err_out, mem_req_out, mem_we_out, busy_out});
    endfunction

    task automatic drv(input logic [31:0] r, ifr, ia, dmr, we, da, wd, mk, rdy, rd);
        rst_in        = r[0];
        if_req_in     = ifr[0];
        if_addr_in    = ia;
        dm_req_in     = dmr[0];
        dm_we_in      = we[0];
        dm_addr_in    = da;
        dm_wdata_in   = wd;
        dm_wr_mask_in = mk[3:0];
        mem_ready_in  = rdy[0];
        mem_rdata_in  = rd;
    endtask

    task automatic idle_in();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        //                 rst ifr ia     dmr we da      wd           mk rdy rd           flags        maddr  be   mwd          ird          drd
        vecs[0] = mkv("reset",      1, 0, 0,     0, 0, 0,     0,           0, 0, 0,           'b0000_0000, 0,     0,   0,           0,           0);
        vecs[1] = mkv("if_gnt",     0, 1, 'h100, 0, 0, 0,     0,           0, 0, 0,           'b1000_0000, 0,     0,   0,           0,           0);
        vecs[2] = mkv("if_serve",   0, 0, 0,     0, 0, 0,     0,           0, 1, 'h00500093,  'b0000_0101, 'h100, 'hF, 0,           0,           0);
        vecs[3] = mkv("if_valid",   0, 0, 0,     0, 0, 0,     0,           0, 0, 0,           'b0100_0000, 'h100, 'hF, 0,           'h00500093,  0);
        vecs[4] = mkv("contend",    0, 1, 'h104, 1, 1, 'h2000, 'hDEADBEEF, 3, 0, 0,           'b0010_0000, 'h100, 'hF, 0,           'h00500093,  0);
        vecs[5] = mkv("st_serve",   0, 1, 'h104, 0, 0, 0,     0,           0, 1, 'h12345678,  'b0000_0111, 'h2000, 3,  'hDEADBEEF,  'h00500093,  0);
        vecs[6] = mkv("st_valid",   0, 1, 'h104, 0, 0, 0,     0,           0, 0, 0,           'b1001_0010, 'h2000, 3,  'hDEADBEEF,  'h00500093,  0);
        vecs[7] = mkv("if2_serve",  0, 0, 0,     0, 0, 0,     0,           0, 1, 'h00000013,  'b0000_0101, 'h104, 'hF, 0,           'h00500093,  0);
        vecs[8] = mkv("if2_valid",  0, 0, 0,     0, 0, 0,     0,           0, 0, 0,           'b0100_0000, 'h104, 'hF, 0,           'h00000013,  0);

        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) next_cycle();

        // Table: reset state, IF-only fetch, DM/IF contention with a masked store.
        for (int i = 0; i < 9; i++) begin
            rst_in        = vecs[i].rst;
            if_req_in     = vecs[i].ifr;
            if_addr_in    = vecs[i].ia;
            dm_req_in     = vecs[i].dmr;
            dm_we_in      = vecs[i].we;
            dm_addr_in    = vecs[i].da;
            dm_wdata_in   = vecs[i].wd;
            dm_wr_mask_in = vecs[i].mk;
            mem_ready_in  = vecs[i].rdy;
            mem_rdata_in  = vecs[i].rd;
            @(negedge clk_in);
            chk({vecs[i].name, ".flags"}, flags_now(), 32'(vecs[i].flags));
            chk({vecs[i].name, ".addr"},  mem_addr_out, vecs[i].maddr);
            chk({vecs[i].name, ".be"},    32'(mem_be_out), 32'(vecs[i].be));
            chk({vecs[i].name, ".wdata"}, mem_wdata_out, vecs[i].mwd);
            chk({vecs[i].name, ".irdata"}, if_rdata_out, vecs[i].ird);
            chk({vecs[i].name, ".drdata"}, dm_rdata_out, vecs[i].drd);
            next_cycle();
        end

        // Ready arriving in the final wait cycle completes normally.
        drv(0, 0, 0, 1, 0, 'h3000, 0, 0, 0, 0);
        @(negedge clk_in);
        chk("t5.gnt", 32'(dm_gnt_out), 1);
        next_cycle();
        idle_in();
        for (int k = 0; k < 15; k++) begin
            @(negedge clk_in);
            chk($sformatf("t5.wait%0d", k), 32'({mem_req_out, dm_valid_out}), 'b10);
            next_cycle();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 'hCAFEF00D);
        @(negedge clk_in);
        chk("t5.last_req", 32'({mem_req_out, busy_out, mem_be_out}), 'b11_1111);
        next_cycle();
        idle_in();
        @(negedge clk_in);
        chk("t5.valid", 32'({dm_valid_out, err_out, busy_out}), 'b100);
        chk("t5.rdata", dm_rdata_out, 'hCAFEF00D);
        next_cycle();

        // No ready at all: abort after the full wait, error pulse, data forced to 0.
        drv(0, 0, 0, 1, 0, 'h3004, 0, 0, 0, 'h5555AAAA);
        @(negedge clk_in);
        chk("t4.gnt", 32'(dm_gnt_out), 1);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h5555AAAA);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_in);
            chk($sformatf("t4.wait%0d", k), 32'({mem_req_out, dm_valid_out}), 'b10);
            next_cycle();
        end
        idle_in();
        @(negedge clk_in);
        chk("t4.timeout", 32'({dm_valid_out, err_out, mem_req_out, busy_out, if_valid_out}), 'b11000);
        chk("t4.rdata", dm_rdata_out, 0);
        next_cycle();
        @(negedge clk_in);
        chk("t4.after", 32'({dm_valid_out, err_out}), 0);
        next_cycle();

        // Reset in the middle of a DM access: no completion pulse afterwards.
        drv(0, 0, 0, 1, 0, 'h4000, 0, 0, 0, 0);
        @(negedge clk_in);
        chk("t1.gnt", 32'(dm_gnt_out), 1);
        next_cycle();
        idle_in();
        @(negedge clk_in);
        chk("t1.serving", 32'({mem_req_out, busy_out}), 'b11);
        next_cycle();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        @(negedge clk_in);
        chk("t1.rst1", 32'({mem_req_out, busy_out, dm_valid_out}), 0);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h77777777);
        @(negedge clk_in);
        chk("t1.rst2", 32'({mem_req_out, busy_out, dm_valid_out}), 0);
        next_cycle();
        idle_in();
        @(negedge clk_in);
        chk("t1.no_pulse", 32'({dm_valid_out, busy_out, mem_req_out}), 0);
        chk("t1.rdata", dm_rdata_out, 0);
        next_cycle();

        // Both requests held: grant pattern with and without the starvation guard.
        drv(0, 1, 'h200, 1, 0, 'h5000, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            chk($sformatf("t6.grant%0d", i), 32'({if_gnt_out, dm_gnt_out}),
                (GUARD && (i % 5 == 4)) ? 'b10 : 'b01);
            next_cycle();
            next_cycle();
        end
        idle_in();
        repeat (2) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
